rc4_crack_ctrl: RTL and testbench
=================================

// Module: rc4_crack_ctrl
// PURPOSE
// - Top-level scheduler for the RC4 brute-force key search.
// - Sequences the init (S[i]=i), KSA-swap and PRGA-decrypt engines through start/done handshakes.
// - Gives the single shared 256x8 S-memory port to whichever engine is active.
// - Checks every decrypted character. Steps the secret key until a plaintext is all lowercase/space or the range is exhausted.
// PARAMETERS
// - KEY_W     24     secret key width in bits
// - KEY_START 0      first key tried after start
// - KEY_END   'h3FFFFF  last key tried; never wraps past this
// PORTS
// - CLOCK_50    in  1      system clock; all logic on its rising edge
// - reset       in  1      synchronous, active-high reset
// - start       in  1      1-cycle pulse; starts a search from KEY_START
// - key         out KEY_W  key currently under test
// - init_start, ksa_start, prga_start  out 1  one-cycle start pulses to the engines
// - init_done, ksa_done, prga_done     in  1  one-cycle completion pulses from the engines
// - prga_abort  out 1      one-cycle pulse telling PRGA to stop (see CONFIGURATION)
// - {init,ksa,prga}_addr  in 8; {init,ksa,prga}_wdata  in 8; {init,ksa,prga}_wren  in 1
// - s_addr      out 8      muxed S-memory address; read data goes straight to all engines
// - s_wdata     out 8      muxed write data
// - s_wren      out 1      muxed write enable
// - char_valid  in  1      PRGA produced a decrypted byte this cycle
// - char_data   in  8      that byte
// - busy        out 1      search in progress
// - done        out 1      search finished; held until next start/reset
// - found       out 1      valid with done: 1 = key found, 0 = exhausted
// - found_key   out KEY_W  winning key; valid when done & found
// BEHAVIOUR
// - FSM states: IDLE, INIT, KSA, PRGA, NEXT, FOUND, EXHAUST.
// - Each engine-phase entry asserts that engine's *_start for exactly the first cycle of the phase.
// - Transitions:
//   - IDLE -start-> INIT; key<=KEY_START.
//   - INIT -init_done-> KSA -ksa_done-> PRGA.
//   - PRGA -prga_done-> FOUND if no bad char was seen this key, else NEXT.
//   - NEXT: if key==KEY_END go to EXHAUST; else key<=key+1 and go to INIT, 1 cycle.
//   - FOUND/EXHAUST: done=1, busy=0, found=(state==FOUND); found_key latched on entry to FOUND.
//   - FOUND/EXHAUST -start-> INIT with key<=KEY_START; done/found cleared.
// - start while busy is ignored. A done pulse from a non-active engine is ignored.
// - Bad-char flag: set on char_valid when char_data is outside 'h61..'h7A and not 'h20; cleared on INIT entry.
// - Char evaluation: char_valid and prga_done in the same cycle both count; the char is evaluated before the FOUND/NEXT decision.
// - Memory mux: owner = active phase engine. Outputs are combinational from state.
//   - In IDLE/NEXT/FOUND/EXHAUST: s_wren=0, s_addr=0, s_wdata=0.
//   - A non-owner's wren never reaches s_wren.
// - Reset values: state IDLE; key=KEY_START; all *_start, prga_abort, s_*, busy, done, found = 0; found_key=0.
// - reset mid-phase: returns to IDLE next edge, with no start pulses and s_wren=0 from that edge.
// CONFIGURATION
// - RC4_EARLY_ABORT_EN defined:
//   - On the first bad char, pulse prga_abort for 1 cycle and go to NEXT on the following cycle without waiting for prga_done.
//   - A prga_done arriving in that same cycle is ignored.
// - RC4_EARLY_ABORT_EN undefined:
//   - prga_abort is tied 0.
//   - The controller always waits for prga_done before deciding.
// STRUCTURE
// - Package rc4_pkg: state enum rc4_state_t; ASCII_LO='h61, ASCII_HI='h7A, ASCII_SP='h20; S_ADDR_W=8, S_DATA_W=8.
// - Sub-module rc4_char_check: registered bad-char flag.
//   - Inputs: clk, clear, char_valid, char_data.
//   - Output: bad.
//   - Also a combinational bad_now output for same-cycle decisions.
// - The memory mux stays inline in rc4_crack_ctrl.
// TESTING (bench uses behavioural stub engines with fixed latencies: init 256, ksa 768, prga 32 chars)
// - reset held 3 cycles -> busy=done=found=0, s_wren=0, key=0, no *_start pulses.
// - start; stub emits all-lowercase text only for key 3 -> keys 0,1,2,3 tried; done=1, found=1, found_key=3, busy=0.
// - Key 0 stub emits 'h41 ('A') as char 5 -> after prga_done, state NEXT, key=1, init_start pulses exactly once.
// - KEY_END=2, all keys bad -> done=1, found=0, key stays 2, no further init_start.
// - During KSA, force init_wren=1 with init_addr='hAA -> s_wren/s_addr follow ksa_* only; no write to 'hAA.
// - reset asserted mid-KSA -> next edge IDLE, s_wren=0, ksa_start not re-pulsed; later start restarts at KEY_START.
// - With RC4_EARLY_ABORT_EN: bad char at index 2 -> prga_abort 1 cycle, next key's init_start within 2 cycles, prga_done ignored.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 brute-force key search.
//   rc4_state_t : scheduler FSM state encoding
//   ASCII_*     : bounds of the accepted plaintext alphabet (a..z and space)
//   S_ADDR_W/S_DATA_W : geometry of the shared 256x8 S-memory port
//   is_plain()  : 1 when a decrypted byte belongs to the accepted alphabet
package rc4_pkg;

  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;

  localparam logic [S_DATA_W-1:0] ASCII_LO = 8'h61;
  localparam logic [S_DATA_W-1:0] ASCII_HI = 8'h7A;
  localparam logic [S_DATA_W-1:0] ASCII_SP = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_KSA     = 3'd2,
    ST_PRGA    = 3'd3,
    ST_NEXT    = 3'd4,
    ST_FOUND   = 3'd5,
    ST_EXHAUST = 3'd6
  } rc4_state_t;

  function automatic logic is_plain(input logic [S_DATA_W-1:0] c);
    return ((c >= ASCII_LO) && (c <= ASCII_HI)) || (c == ASCII_SP);
  endfunction

endpackage

// File: rtl/rc4_char_check.sv
// rc4_char_check: plaintext quality flag for one candidate key.
// Ports:
//   clk        in  clock, rising edge
//   clear      in  synchronous clear of the flag (dominates a same-cycle bad char)
//   char_valid in  char_data holds a decrypted byte this cycle
//   char_data  in  decrypted byte
//   bad        out registered: some earlier byte since the last clear was bad
//   bad_now    out combinational: the byte presented this cycle is bad
// The controller ORs bad and bad_now so a bad byte arriving together with the
// PRGA completion pulse still counts against the key.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic                clk,
  input  logic                clear,
  input  logic                char_valid,
  input  logic [S_DATA_W-1:0] char_data,
  output logic                bad,
  output logic                bad_now
);

  logic bad_q;
  logic bad_d;

  assign bad_now = char_valid && !is_plain(char_data);

  always_comb begin
    bad_d = bad_q;
    if (clear) begin
      bad_d = 1'b0;
    end else if (bad_now) begin
      bad_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    bad_q <= bad_d;
  end

  assign bad = bad_q;

endmodule

// File: rtl/rc4_crack_ctrl.sv
// rc4_crack_ctrl: top-level scheduler of the RC4 brute-force key search.
// Walks the secret key from KEY_START to KEY_END; for every key it runs the
// init (S[i]=i), KSA-swap and PRGA-decrypt engines in turn, grades each
// decrypted byte, and stops on the first key whose plaintext is entirely
// lowercase letters and spaces, or after KEY_END has failed.
//
// Optional feature (compile-time macro RC4_EARLY_ABORT_EN):
//   defined   - the first bad byte pulses prga_abort and moves to the next key
//               without waiting for prga_done.
//   undefined - prga_abort is tied low; every key waits for prga_done.
//
// Ports:
//   CLOCK_50                          in   clock, all logic on its rising edge
//   reset                             in   synchronous, active-high reset
//   start                             in   1-cycle pulse, begins a search (ignored while busy)
//   key                               out  key currently under test
//   init_start/ksa_start/prga_start   out  1-cycle engine start pulses
//   init_done/ksa_done/prga_done      in   1-cycle engine completion pulses
//   prga_abort                        out  1-cycle PRGA stop request
//   {init,ksa,prga}_{addr,wdata,wren} in   per-engine S-memory requests
//   s_addr/s_wdata/s_wren             out  S-memory port granted to the active engine
//   char_valid/char_data              in   decrypted byte stream from PRGA
//   busy/done/found/found_key         out  search status and result
//   dbg_state                         out  current FSM state
//
// Engine handshake: the controller raises <eng>_start for exactly the first
// cycle it spends in that engine's phase. The engine answers, some cycles
// later, with a single-cycle <eng>_done. A done pulse is acted on only while
// the controller is in that engine's phase; otherwise it is dropped. While a
// phase is active, only that engine's address/data/write-enable reach the
// S-memory port.
module rc4_crack_ctrl
  import rc4_pkg::*;
#(
  parameter int unsigned       KEY_W     = 24,
  parameter logic [KEY_W-1:0]  KEY_START = '0,
  parameter logic [KEY_W-1:0]  KEY_END   = KEY_W'(24'h3FFFFF)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  output logic [KEY_W-1:0]    key,

  output logic                init_start,
  output logic                ksa_start,
  output logic                prga_start,
  input  logic                init_done,
  input  logic                ksa_done,
  input  logic                prga_done,
  output logic                prga_abort,

  input  logic [S_ADDR_W-1:0] init_addr,
  input  logic [S_DATA_W-1:0] init_wdata,
  input  logic                init_wren,
  input  logic [S_ADDR_W-1:0] ksa_addr,
  input  logic [S_DATA_W-1:0] ksa_wdata,
  input  logic                ksa_wren,
  input  logic [S_ADDR_W-1:0] prga_addr,
  input  logic [S_DATA_W-1:0] prga_wdata,
  input  logic                prga_wren,

  output logic [S_ADDR_W-1:0] s_addr,
  output logic [S_DATA_W-1:0] s_wdata,
  output logic                s_wren,

  input  logic                char_valid,
  input  logic [S_DATA_W-1:0] char_data,

  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [KEY_W-1:0]    found_key,
  output rc4_state_t          dbg_state
);

  rc4_state_t       state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] found_key_q, found_key_d;
  // Set for the first cycle after any state change; qualifies the start pulses.
  logic             first_q;

  logic             chk_clear;
  logic             chk_valid;
  logic             bad_seen;
  logic             bad_now;
  logic             abort_now;

  // ---------------------------------------------------------------------------
  // Plaintext grading. Bytes only count while PRGA owns the phase; the flag is
  // wiped for the whole INIT phase so each key starts clean.
  // ---------------------------------------------------------------------------
  assign chk_valid = char_valid && (state_q == ST_PRGA);
  assign chk_clear = reset || (state_q == ST_INIT);

  rc4_char_check u_char_check (
    .clk        (CLOCK_50),
    .clear      (chk_clear),
    .char_valid (chk_valid),
    .char_data  (char_data),
    .bad        (bad_seen),
    .bad_now    (bad_now)
  );

`ifdef RC4_EARLY_ABORT_EN
  // Leaving PRGA on the first bad byte means bad_seen can never already be
  // set here, so bad_now alone marks the first one.
  assign abort_now = (state_q == ST_PRGA) && bad_now;
`else
  assign abort_now = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    found_key_d = found_key_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          key_d   = KEY_START;
        end
      end

      ST_INIT: begin
        if (init_done) begin
          state_d = ST_KSA;
        end
      end

      ST_KSA: begin
        if (ksa_done) begin
          state_d = ST_PRGA;
        end
      end

      ST_PRGA: begin
        // An abort wins over a coincident prga_done: the key is already lost.
        if (abort_now) begin
          state_d = ST_NEXT;
        end else if (prga_done) begin
          if (bad_seen || bad_now) begin
            state_d = ST_NEXT;
          end else begin
            state_d     = ST_FOUND;
            found_key_d = key_q;
          end
        end
      end

      ST_NEXT: begin
        // KEY_END is the last key tried; the counter never wraps past it.
        if (key_q == KEY_END) begin
          state_d = ST_EXHAUST;
        end else begin
          key_d   = key_q + KEY_W'(1);
          state_d = ST_INIT;
        end
      end

      ST_FOUND, ST_EXHAUST: begin
        if (start) begin
          state_d = ST_INIT;
          key_d   = KEY_START;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      key_q       <= KEY_START;
      found_key_q <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      found_key_q <= found_key_d;
      first_q     <= (state_d != state_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Status and engine control
  // ---------------------------------------------------------------------------
  assign init_start = (state_q == ST_INIT) && first_q;
  assign ksa_start  = (state_q == ST_KSA)  && first_q;
  assign prga_start = (state_q == ST_PRGA) && first_q;
  assign prga_abort = abort_now;

  assign busy      = (state_q == ST_INIT) || (state_q == ST_KSA) ||
                     (state_q == ST_PRGA) || (state_q == ST_NEXT);
  assign done      = (state_q == ST_FOUND) || (state_q == ST_EXHAUST);
  assign found     = (state_q == ST_FOUND);
  assign found_key = found_key_q;
  assign key       = key_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // S-memory port mux: purely a function of the registered state, so a stray
  // request from an idle engine can never reach the memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wren  = 1'b0;
    case (state_q)
      ST_INIT: begin
        s_addr  = init_addr;
        s_wdata = init_wdata;
        s_wren  = init_wren;
      end
      ST_KSA: begin
        s_addr  = ksa_addr;
        s_wdata = ksa_wdata;
        s_wren  = ksa_wren;
      end
      ST_PRGA: begin
        s_addr  = prga_addr;
        s_wdata = prga_wdata;
        s_wren  = prga_wren;
      end
      default: begin
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_crack_ctrl.sv
// tb_rc4_crack_ctrl: directed bench for rc4_crack_ctrl with behavioural stub
// engines (init 256 writes, KSA 768 cycles, PRGA 32 bytes). A second instance
// with KEY_END=2 runs in lockstep with the first for the exhaustion case.
// Build with RC4_EARLY_ABORT_EN defined to cover the early-abort variant.
module tb_rc4_crack_ctrl;
  import rc4_pkg::*;

  localparam int KEY_W = 24;
  localparam int W     = 32;

  localparam int MODE_FIND   = 0;  // only key 3 decrypts to clean text
  localparam int MODE_ALLBAD = 1;  // every key has a bad byte at index 10
  localparam int MODE_EARLY  = 2;  // key 0: bad byte and prga_done both at index 2

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic start_x;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic [KEY_W-1:0] key, found_key, key_x, found_key_x;
  logic init_start, ksa_start, prga_start, prga_abort;
  logic init_start_x, ksa_start_x, prga_start_x, prga_abort_x;
  logic busy, done, found, busy_x, done_x, found_x;
  logic [7:0] s_addr, s_wdata, s_addr_x, s_wdata_x;
  logic s_wren, s_wren_x;
  rc4_state_t dbg_state, dbg_state_x;

  logic init_done, ksa_done, prga_done;
  logic [7:0] init_addr, init_wdata, ksa_addr, ksa_wdata, prga_addr, prga_wdata;
  logic init_wren, ksa_wren, prga_wren;
  logic char_valid;
  logic [7:0] char_data;

  rc4_crack_ctrl #(.KEY_W(KEY_W)) dut (
    .CLOCK_50 (clk), .reset (reset), .start (start), .key (key),
    .init_start (init_start), .ksa_start (ksa_start), .prga_start (prga_start),
    .init_done (init_done), .ksa_done (ksa_done), .prga_done (prga_done),
    .prga_abort (prga_abort),
    .init_addr (init_addr), .init_wdata (init_wdata), .init_wren (init_wren),
    .ksa_addr (ksa_addr), .ksa_wdata (ksa_wdata), .ksa_wren (ksa_wren),
    .prga_addr (prga_addr), .prga_wdata (prga_wdata), .prga_wren (prga_wren),
    .s_addr (s_addr), .s_wdata (s_wdata), .s_wren (s_wren),
    .char_valid (char_valid), .char_data (char_data),
    .busy (busy), .done (done), .found (found), .found_key (found_key),
    .dbg_state (dbg_state)
  );

  rc4_crack_ctrl #(.KEY_W(KEY_W), .KEY_END(24'd2)) dut_x (
    .CLOCK_50 (clk), .reset (reset), .start (start_x), .key (key_x),
    .init_start (init_start_x), .ksa_start (ksa_start_x), .prga_start (prga_start_x),
    .init_done (init_done), .ksa_done (ksa_done), .prga_done (prga_done),
    .prga_abort (prga_abort_x),
    .init_addr (init_addr), .init_wdata (init_wdata), .init_wren (init_wren),
    .ksa_addr (ksa_addr), .ksa_wdata (ksa_wdata), .ksa_wren (ksa_wren),
    .prga_addr (prga_addr), .prga_wdata (prga_wdata), .prga_wren (prga_wren),
    .s_addr (s_addr_x), .s_wdata (s_wdata_x), .s_wren (s_wren_x),
    .char_valid (char_valid), .char_data (char_data),
    .busy (busy_x), .done (done_x), .found (found_x), .found_key (found_key_x),
    .dbg_state (dbg_state_x)
  );

  // ---------------------------------------------------------------------------
  // Stub engines (follow the first instance's start pulses)
  // ---------------------------------------------------------------------------
  int         mode;
  logic       force_init;
  logic       init_busy;
  logic [7:0] init_cnt;
  logic       ksa_busy;
  logic [9:0] ksa_cnt;
  logic       prga_busy;
  logic [5:0] prga_cnt;
  logic [5:0] prga_last;
  logic [KEY_W-1:0] prga_key;

  always @(posedge clk) begin
    init_done <= 1'b0;
    if (reset) begin
      init_busy <= 1'b0;
      init_cnt  <= 8'd0;
    end else if (init_start) begin
      init_busy <= 1'b1;
      init_cnt  <= 8'd0;
    end else if (init_busy) begin
      init_cnt <= init_cnt + 8'd1;
      if (init_cnt == 8'd255) begin
        init_busy <= 1'b0;
        init_done <= 1'b1;
      end
    end
  end
  assign init_wren  = init_busy | force_init;
  assign init_addr  = force_init ? 8'hAA : init_cnt;
  assign init_wdata = force_init ? 8'h55 : init_cnt;

  always @(posedge clk) begin
    ksa_done <= 1'b0;
    if (reset) begin
      ksa_busy <= 1'b0;
      ksa_cnt  <= 10'd0;
    end else if (ksa_start) begin
      ksa_busy <= 1'b1;
      ksa_cnt  <= 10'd0;
    end else if (ksa_busy) begin
      ksa_cnt <= ksa_cnt + 10'd1;
      if (ksa_cnt == 10'd767) begin
        ksa_busy <= 1'b0;
        ksa_done <= 1'b1;
      end
    end
  end
  // Odd addresses only, so any write seen at 'hAA during KSA is a leak.
  assign ksa_addr  = {ksa_cnt[6:0], 1'b1};
  assign ksa_wdata = ksa_cnt[7:0] ^ 8'h3C;
  assign ksa_wren  = ksa_busy & ksa_cnt[0];

  function automatic logic [7:0] stub_char(input int m, input logic [KEY_W-1:0] k,
                                           input logic [5:0] i);
    logic [7:0] c;
    c = 8'h61 + ({2'b00, i} % 8'd26);
    if (i == 6'd1) c = 8'h7A;
    if (i == 6'd2) c = 8'h20;
    if (m == MODE_FIND) begin
      if (k == 24'd0 && i == 6'd5)  c = 8'h41;
      if (k == 24'd1 && i == 6'd31) c = 8'h7B;
      if (k == 24'd2 && i == 6'd0)  c = 8'h60;
    end else if (m == MODE_ALLBAD) begin
      if (i == 6'd10) c = 8'h5A;
    end else if (m == MODE_EARLY) begin
      if (k == 24'd0 && i == 6'd2) c = 8'h7F;
    end
    return c;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      prga_busy <= 1'b0;
      prga_cnt  <= 6'd0;
      prga_key  <= '0;
    end else if (prga_start) begin
      prga_busy <= 1'b1;
      prga_cnt  <= 6'd0;
      prga_key  <= key;
    end else if (prga_busy) begin
      prga_cnt <= prga_cnt + 6'd1;
      if (prga_done || prga_abort) prga_busy <= 1'b0;
    end
  end
  assign prga_last  = (mode == MODE_EARLY && prga_key == 24'd0) ? 6'd2 : 6'd31;
  assign prga_done  = prga_busy && (prga_cnt == prga_last);
  assign char_valid = prga_busy;
  assign char_data  = stub_char(mode, prga_key, prga_cnt);
  assign prga_addr  = {2'b00, prga_cnt} + 8'h10;
  assign prga_wdata = ~{2'b00, prga_cnt};
  assign prga_wren  = prga_busy & prga_cnt[0];

  // ---------------------------------------------------------------------------
  // Scoreboard and monitors
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int mux_err = 0;
  int aa_writes = 0;
  int init_pulses = 0;
  int init_pulses_x = 0;
  int ksa_pulses = 0;
  int abort_pulses = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tried_q[$];
  logic [7:0] ea, ed;
  logic       ew;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      case (dbg_state)
        ST_INIT: begin ea = init_addr; ed = init_wdata; ew = init_wren; end
        ST_KSA:  begin ea = ksa_addr;  ed = ksa_wdata;  ew = ksa_wren;  end
        ST_PRGA: begin ea = prga_addr; ed = prga_wdata; ew = prga_wren; end
        default: begin ea = 8'h00;     ed = 8'h00;      ew = 1'b0;      end
      endcase
      if (s_addr !== ea || s_wdata !== ed || s_wren !== ew) mux_err++;
      if (force_init && s_wren && s_addr == 8'hAA) aa_writes++;
      if (init_start) begin
        init_pulses++;
        tried_q.push_back(W'(key));
      end
      if (ksa_start) ksa_pulses++;
      if (prga_abort) abort_pulses++;
      if (init_start_x) init_pulses_x++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic pulse_start(input logic a, input logic b);
    start   = a;
    start_x = b;
    @(negedge clk);
    start   = 1'b0;
    start_x = 1'b0;
  endtask

  task automatic wait_state(input logic use_x, input rc4_state_t st, input int budget,
                            input string tag);
    int n;
    n = 0;
    while (((use_x ? dbg_state_x : dbg_state) !== st) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, W'((use_x ? dbg_state_x : dbg_state) === st), 1);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int snap;
    int n;
    logic [W-1:0] e, g;

    mode = MODE_FIND;
    force_init = 1'b0;
    start = 1'b0;
    start_x = 1'b0;
    reset = 1'b1;

    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_found", found, 0);
    check_eq("rst_s_wren", s_wren, 0);
    check_eq("rst_s_addr", s_addr, 0);
    check_eq("rst_key", key, 0);
    check_eq("rst_found_key", found_key, 0);
    check_eq("rst_starts", {init_start, ksa_start, prga_start}, 0);
    check_eq("rst_abort", prga_abort, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);

    // Search: only key 3 is clean
    pulse_start(1'b1, 1'b0);
    check_eq("k0_init_start", init_start, 1);
    check_eq("k0_key", key, 0);
    check_eq("k0_busy", busy, 1);
    @(negedge clk);
    check_eq("k0_init_start_once", init_start, 0);
    wait_state(1'b0, ST_NEXT, 3000, "k0_reach_next");
    check_eq("k0_next_key", key, 0);
    @(negedge clk);
    check_eq("k1_state", dbg_state, ST_INIT);
    check_eq("k1_key", key, 1);
    check_eq("k1_init_start", init_start, 1);
    @(negedge clk);
    check_eq("k1_init_start_once", init_start, 0);

    // start while busy must not restart the search
    wait_state(1'b0, ST_KSA, 600, "k1_reach_ksa");
    pulse_start(1'b1, 1'b0);
    check_eq("busy_start_state", dbg_state, ST_KSA);
    check_eq("busy_start_key", key, 1);

    wait_state(1'b0, ST_FOUND, 5000, "find_reach_found");
    check_eq("find_done", done, 1);
    check_eq("find_found", found, 1);
    check_eq("find_found_key", found_key, 3);
    check_eq("find_busy", busy, 0);
    check_eq("find_tried_count", tried_q.size(), 4);
    for (int k = 0; k < 4; k++) exp_q.push_back(W'(k));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (tried_q.size() > 0) ? tried_q.pop_front() : '1;
      check_eq("find_tried_key", g, e);
    end
    repeat (5) @(negedge clk);
    check_eq("find_done_held", done, 1);
    check_eq("idle_peer_ignores_done", dbg_state_x, ST_IDLE);

    // Restart from FOUND, then foreign write during KSA, then reset mid-KSA
    pulse_start(1'b1, 1'b0);
    check_eq("restart_state", dbg_state, ST_INIT);
    check_eq("restart_key", key, 0);
    check_eq("restart_done", done, 0);
    check_eq("restart_found", found, 0);
    wait_state(1'b0, ST_KSA, 600, "restart_reach_ksa");
    repeat (20) @(negedge clk);
    force_init = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("ksa_owner_addr", s_addr, ksa_addr);
    check_eq("ksa_owner_wren", s_wren, ksa_wren);
    check_eq("ksa_no_write_aa", aa_writes, 0);
    force_init = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_eq("midksa_rst_state", dbg_state, ST_IDLE);
    check_eq("midksa_rst_wren", s_wren, 0);
    check_eq("midksa_rst_ksa_start", ksa_start, 0);
    check_eq("midksa_rst_busy", busy, 0);
    reset = 1'b0;
    snap = ksa_pulses;
    repeat (30) @(negedge clk);
    check_eq("midksa_no_ksa_repulse", ksa_pulses - snap, 0);
    pulse_start(1'b1, 1'b0);
    check_eq("after_rst_key", key, 0);
    check_eq("after_rst_init_start", init_start, 1);
    do_reset(2);

    // Exhaustion on the KEY_END=2 instance, every key bad
    mode = MODE_ALLBAD;
    pulse_start(1'b1, 1'b1);
    check_eq("exh_start_state", dbg_state_x, ST_INIT);
    wait_state(1'b1, ST_EXHAUST, 4500, "exh_reach_exhaust");
    check_eq("exh_done", done_x, 1);
    check_eq("exh_found", found_x, 0);
    check_eq("exh_busy", busy_x, 0);
    check_eq("exh_key", key_x, 2);
    check_eq("exh_init_pulses", init_pulses_x, 3);
    snap = init_pulses_x;
    repeat (1200) @(negedge clk);
    check_eq("exh_no_more_init", init_pulses_x - snap, 0);
    check_eq("exh_key_held", key_x, 2);
    check_eq("exh_done_held", done_x, 1);
    do_reset(2);

`ifdef RC4_EARLY_ABORT_EN
    // Early abort: bad byte at index 2 coincides with prga_done
    mode = MODE_EARLY;
    snap = abort_pulses;
    pulse_start(1'b1, 1'b0);
    n = 0;
    while (prga_abort !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("early_abort_seen", prga_abort, 1);
    check_eq("early_abort_key", key, 0);
    check_eq("early_abort_state", dbg_state, ST_PRGA);
    @(negedge clk);
    check_eq("early_abort_one_cycle", prga_abort, 0);
    check_eq("early_next_state", dbg_state, ST_NEXT);
    @(negedge clk);
    check_eq("early_next_init_start", init_start, 1);
    check_eq("early_next_key", key, 1);
    wait_state(1'b0, ST_FOUND, 2000, "early_reach_found");
    check_eq("early_found_key", found_key, 1);
    check_eq("early_abort_count", abort_pulses - snap, 1);
`else
    check_eq("abort_tied_low", abort_pulses, 0);
`endif

    check_eq("mux_follows_owner", mux_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
